// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares the write port of one synchronous FIFO between NREQ producers.
// Arbitration is round-robin between packets and packet-atomic within a
// packet: once a producer moves a non-last beat it keeps the write port
// until its last beat goes through. Grant and write enable are combinational
// from the valids so a beat can move in the same cycle it is offered.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DSIZE-1:0]      fifo_din,
  output logic [IDW-1:0]        fifo_src,
  output logic                  lock_active,
  output logic [IDW-1:0]        lock_owner,
  output logic [15:0]           pkt_cnt
);

  // Arbiter states: free for a new packet, or held by a packet in flight.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Requester count at index width plus one, so sums of two indices compare
  // against it without overflow.
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] IDX_ONE = IDW'(1);

  // (base + off) mod NREQ for base, off < NREQ. One conditional subtract is
  // enough, and the result never reaches NREQ even when NREQ is not a power
  // of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input logic [IDW-1:0] off);
    logic [IDW:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= NREQ_W) begin
      sum = sum - NREQ_W;
    end else begin
      sum = sum;
    end
    return sum[IDW-1:0];
  endfunction

  // Registered arbitration state.
  logic [0:0]     state_r;
  logic [IDW-1:0] owner_r;
  logic [IDW-1:0] rr_ptr_r;
  logic [15:0]    pkt_cnt_r;

  // Next-state values.
  logic [0:0]     state_nxt_s;
  logic [IDW-1:0] owner_nxt_s;
  logic [IDW-1:0] rr_ptr_nxt_s;
  logic [15:0]    pkt_cnt_nxt_s;

  // Arbitration datapath.
  logic           cand_found_s;
  logic [IDW-1:0] cand_s;
  logic [IDW-1:0] sel_s;
  logic           sel_avail_s;
  logic           grant_en_s;
  logic           xfer_s;
  logic           sel_last_s;
  logic [NREQ-1:0] ready_s;

  // Round-robin candidate: first valid requester scanning upward from rr_ptr.
  always_comb begin
    logic [IDW-1:0] idx_v;
    cand_found_s = 1'b0;
    cand_s       = '0;
    idx_v        = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = wrap_add(rr_ptr_r, IDW'(k));
      if (!cand_found_s && req_valid[idx_v]) begin
        cand_found_s = 1'b1;
        cand_s       = idx_v;
      end else begin
        cand_found_s = cand_found_s;
      end
    end
  end

  // Pick the port being served: the lock owner while locked (even when it
  // has no beat, so others stay blocked), else the round-robin candidate.
  always_comb begin
    if (state_r == ST_LOCKED) begin
      sel_s       = owner_r;
      sel_avail_s = 1'b1;
    end else begin
      sel_s       = cand_s;
      sel_avail_s = cand_found_s;
    end
  end

  // A grant is only possible out of reset and with room in the FIFO.
  assign grant_en_s = rstn & ~fifo_full & sel_avail_s;
  assign xfer_s     = grant_en_s & req_valid[sel_s];
  assign sel_last_s = req_last[sel_s];

  // One-hot ready toward the selected requester; at most one bit is ever set.
  always_comb begin
    ready_s = '0;
    if (grant_en_s) begin
      ready_s[sel_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign req_ready  = ready_s;
  assign fifo_wr_en = xfer_s;
  assign fifo_din   = req_data[sel_s*DSIZE +: DSIZE];
  assign fifo_src   = sel_s;

  // Next-state decision: lock on a non-last beat, release and advance the
  // pointer past the sender on a last beat. Nothing changes without a transfer.
  always_comb begin
    state_nxt_s   = state_r;
    owner_nxt_s   = owner_r;
    rr_ptr_nxt_s  = rr_ptr_r;
    pkt_cnt_nxt_s = pkt_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          if (sel_last_s) begin
            rr_ptr_nxt_s  = wrap_add(sel_s, IDX_ONE);
            pkt_cnt_nxt_s = pkt_cnt_r + 16'd1;
          end else begin
            state_nxt_s = ST_LOCKED;
            owner_nxt_s = sel_s;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (xfer_s && sel_last_s) begin
          state_nxt_s   = ST_IDLE;
          owner_nxt_s   = '0;
          rr_ptr_nxt_s  = wrap_add(owner_r, IDX_ONE);
          pkt_cnt_nxt_s = pkt_cnt_r + 16'd1;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        owner_nxt_s   = '0;
        rr_ptr_nxt_s  = '0;
        pkt_cnt_nxt_s = pkt_cnt_r;
      end
    endcase
  end

  // State registers; reset drops any lock at once and restarts at requester 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      owner_r   <= '0;
      rr_ptr_r  <= '0;
      pkt_cnt_r <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      owner_r   <= owner_nxt_s;
      rr_ptr_r  <= rr_ptr_nxt_s;
      pkt_cnt_r <= pkt_cnt_nxt_s;
    end
  end

  // Status straight from flops; owner is cleared on release so it reads 0
  // whenever no packet is in flight.
  assign lock_active = (state_r == ST_LOCKED);
  assign lock_owner  = owner_r;
  assign pkt_cnt     = pkt_cnt_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DSIZE=8): reset, round robin,
// packet atomicity, full stall, owner bubble and async reset mid-packet.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [1:0]  fifo_src;
  logic        lock_active;
  logic [1:0]  lock_owner;
  logic [15:0] pkt_cnt;

  int n_assert;
  int n_fail;

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .fifo_src    (fifo_src),
    .lock_active (lock_active),
    .lock_owner  (lock_owner),
    .pkt_cnt     (pkt_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    req_valid = 4'h0;
    req_last  = 4'h0;
    req_data  = 32'h0;
    fifo_full = 1'b0;

    // Reset with every requester valid
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    req_last  = 4'hF;
    #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_lock", lock_active, 1'b0);
    chk("rst_owner", lock_owner, 2'd0);
    chk("rst_pkt", pkt_cnt, 16'd0);

    // Single-beat round robin over 8 cycles
    req_data = 32'hA3A2A1A0;
    rstn = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_wr_en", fifo_wr_en, 1'b1);
      chk("rr_src", fifo_src, 32'(i % 4));
      chk("rr_din", fifo_din, 32'(8'hA0 + (i % 4)));
      chk("rr_ready", req_ready, 32'(1 << (i % 4)));
      tick();
    end
    chk("rr_pkt", pkt_cnt, 16'd8);

    // Move rr_ptr to 1 with a single beat from requester 0
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    #1;
    chk("pre_src", fifo_src, 2'd0);
    tick();
    chk("pre_pkt", pkt_cnt, 16'd9);

    // Packet atomicity: req1 three beats, req0/req2 single beats waiting
    req_valid = 4'b0111;
    req_last  = 4'b0101;
    req_data  = 32'h00C2A1B0;
    #1;
    chk("atom_a1_src", fifo_src, 2'd1);
    chk("atom_a1_din", fifo_din, 8'hA1);
    chk("atom_a1_ready", req_ready, 4'b0010);
    tick();
    chk("atom_lock1", lock_active, 1'b1);
    chk("atom_owner1", lock_owner, 2'd1);
    req_data[15:8] = 8'hA2;
    #1;
    chk("atom_a2_src", fifo_src, 2'd1);
    chk("atom_a2_din", fifo_din, 8'hA2);
    chk("atom_a2_ready", req_ready, 4'b0010);
    tick();
    chk("atom_lock2", lock_active, 1'b1);
    req_data[15:8] = 8'hA3;
    req_last[1] = 1'b1;
    #1;
    chk("atom_a3_src", fifo_src, 2'd1);
    chk("atom_a3_din", fifo_din, 8'hA3);
    tick();
    chk("atom_unlock", lock_active, 1'b0);
    chk("atom_pkt", pkt_cnt, 16'd10);
    req_valid[1] = 1'b0;
    #1;
    chk("atom_c2_src", fifo_src, 2'd2);
    chk("atom_c2_din", fifo_din, 8'hC2);
    tick();
    req_valid[2] = 1'b0;
    #1;
    chk("atom_b0_src", fifo_src, 2'd0);
    chk("atom_b0_din", fifo_din, 8'hB0);
    tick();
    chk("atom_pkt2", pkt_cnt, 16'd12);
    req_valid = 4'b0000;
    req_last  = 4'b0000;

    // Full stall while req2 is locked
    req_valid = 4'b0100;
    req_data[23:16] = 8'hD1;
    #1;
    chk("full_d1_src", fifo_src, 2'd2);
    chk("full_d1_wr", fifo_wr_en, 1'b1);
    tick();
    chk("full_owner", lock_owner, 2'd2);
    req_data[23:16] = 8'hD2;
    req_valid = 4'b0101;
    req_last  = 4'b0001;
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("full_wr_en", fifo_wr_en, 1'b0);
      chk("full_ready", req_ready, 4'b0000);
      chk("full_owner_hold", lock_owner, 2'd2);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    chk("full_d2_wr", fifo_wr_en, 1'b1);
    chk("full_d2_src", fifo_src, 2'd2);
    chk("full_d2_din", fifo_din, 8'hD2);
    chk("full_d2_ready", req_ready, 4'b0100);
    tick();
    req_data[23:16] = 8'hD3;
    req_last[2] = 1'b1;
    #1;
    chk("full_d3_din", fifo_din, 8'hD3);
    chk("full_d3_ready", req_ready, 4'b0100);
    tick();
    chk("full_unlock", lock_active, 1'b0);
    chk("full_pkt", pkt_cnt, 16'd13);
    req_valid[2] = 1'b0;
    #1;
    chk("full_b0_src", fifo_src, 2'd0);
    chk("full_b0_ready", req_ready, 4'b0001);
    tick();
    chk("full_pkt2", pkt_cnt, 16'd14);
    req_valid = 4'b0000;
    req_last  = 4'b0000;

    // Owner bubble: req3 locked, req0 waiting
    req_valid = 4'b1000;
    req_data[31:24] = 8'hE1;
    #1;
    chk("bub_e1_src", fifo_src, 2'd3);
    chk("bub_e1_wr", fifo_wr_en, 1'b1);
    tick();
    chk("bub_owner", lock_owner, 2'd3);
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bub_wr_en", fifo_wr_en, 1'b0);
      chk("bub_ready0", req_ready[0], 1'b0);
      chk("bub_owner_hold", lock_owner, 2'd3);
      tick();
    end
    req_valid = 4'b1001;
    req_last  = 4'b1001;
    req_data[31:24] = 8'hE2;
    #1;
    chk("bub_e2_src", fifo_src, 2'd3);
    chk("bub_e2_din", fifo_din, 8'hE2);
    chk("bub_e2_wr", fifo_wr_en, 1'b1);
    tick();
    chk("bub_unlock", lock_active, 1'b0);
    chk("bub_pkt", pkt_cnt, 16'd15);
    req_valid[3] = 1'b0;
    #1;
    chk("bub_b0_src", fifo_src, 2'd0);
    chk("bub_b0_wr", fifo_wr_en, 1'b1);
    tick();
    chk("bub_pkt2", pkt_cnt, 16'd16);

    // Async reset while req1 holds the lock
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    req_data[15:8] = 8'h5A;
    #1;
    chk("ar_lock_src", fifo_src, 2'd1);
    tick();
    chk("ar_locked", lock_active, 1'b1);
    chk("ar_owner", lock_owner, 2'd1);
    req_valid = 4'b0011;
    req_last  = 4'b0001;
    #1;
    chk("ar_pre_ready", req_ready, 4'b0010);
    rstn = 1'b0;
    #1;
    chk("ar_lock_drop", lock_active, 1'b0);
    chk("ar_owner_clr", lock_owner, 2'd0);
    chk("ar_ready", req_ready, 4'b0000);
    chk("ar_wr_en", fifo_wr_en, 1'b0);
    chk("ar_pkt", pkt_cnt, 16'd0);
    rstn = 1'b1;
    #1;
    chk("ar_rel_ready", req_ready, 4'b0001);
    chk("ar_rel_src", fifo_src, 2'd0);
    chk("ar_rel_wr", fifo_wr_en, 1'b1);
    chk("ar_rel_pkt", pkt_cnt, 16'd0);
    tick();
    chk("ar_pkt1", pkt_cnt, 16'd1);
    chk("ar_idle", lock_active, 1'b0);
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    #1;
    chk("ar_r1_src", fifo_src, 2'd1);
    chk("ar_r1_din", fifo_din, 8'h5A);
    tick();
    chk("ar_pkt2", pkt_cnt, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of a single synchronous FIFO between NREQ producers.
- Arbitration is round-robin and packet-atomic: once a producer transfers a non-last beat, it owns the FIFO write port until its last beat.
- Sits directly in front of the FIFO: drives its write enable and data, and observes its full flag.
- Also exports the current owner and a completed-packet counter for debug and status.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DSIZE, 8, data width per beat; must equal the FIFO DSIZE.
- IDW, $clog2(NREQ), width of requester index fields.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rstn, input, 1, asynchronous active-low reset.
- req_valid, input, NREQ, per-requester beat valid.
- req_last, input, NREQ, per-requester last-beat-of-packet flag, qualified by req_valid.
- req_data, input, NREQ*DSIZE, requester i occupies bits [i*DSIZE +: DSIZE].
- req_ready, output, NREQ, per-requester beat accepted this cycle.
- fifo_full, input, 1, FIFO full flag.
- fifo_wr_en, output, 1, FIFO write enable.
- fifo_din, output, DSIZE, FIFO write data.
- fifo_src, output, IDW, index of the requester whose beat is on fifo_din.
- lock_active, output, 1, a packet is in progress.
- lock_owner, output, IDW, owner while lock_active, else 0.
- pkt_cnt, output, 16, completed packets.

Behaviour:
- Handshake:
  - A beat from requester i transfers in a cycle where req_valid[i] & req_ready[i].
  - At most one req_ready bit is high per cycle.
  - fifo_wr_en = OR of all transfers; fifo_din and fifo_src carry the transferring requester's data and index.
  - Zero-latency (combinational) path from valid to ready and wr_en.
- Requester rules: once valid is asserted, req_valid, req_data and req_last must hold until transfer. The arbiter does not check this.
- State (registered): IDLE / LOCKED, plus owner[IDW] and rr_ptr[IDW].
- IDLE:
  - Candidate = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[cand] = ~fifo_full.
  - On transfer with last=1: stay IDLE, rr_ptr <= (cand+1) mod NREQ, pkt_cnt++.
  - On transfer with last=0: go to LOCKED, owner <= cand.
  - No transfer (no valid, or full): state and rr_ptr unchanged. The candidate may change next cycle; nothing is latched without a transfer.
- LOCKED:
  - req_ready[owner] = ~fifo_full; all other ready bits are 0, regardless of their valid.
  - On owner transfer with last=1: go to IDLE, rr_ptr <= (owner+1) mod NREQ, pkt_cnt++.
  - Owner valid low (bubble): no write; lock held indefinitely.
- fifo_full = 1: all req_ready = 0 and fifo_wr_en = 0 in any state. State holds.
- lock_active = (state == LOCKED); lock_owner = owner when LOCKED, else 0.
- pkt_cnt wraps 0xFFFF -> 0x0000.
- Modulo wrap: rr_ptr wraps from NREQ-1 to 0. For non-power-of-2 NREQ, the index must never reach ≥ NREQ.
- Reset (rstn low, asynchronous):
  - State IDLE, owner 0, rr_ptr 0, pkt_cnt 0.
  - While rstn is low, req_ready = 0 and fifo_wr_en = 0. fifo_din and fifo_src are don't-care when fifo_wr_en = 0.
- Reset mid-packet: the lock is dropped immediately. Any partial packet already in the FIFO stays there; discarding it is the downstream's responsibility.
- Reset release: first arbitration starts at requester 0.

Test Plan:
- Reset: assert rstn low with all req_valid high -> req_ready=0000, fifo_wr_en=0, lock_active=0, pkt_cnt=0.
- Single-beat round robin: NREQ=4, all valid with last=1, fifo_full=0 for 8 cycles -> fifo_src 0,1,2,3,0,1,2,3, fifo_wr_en=1 every cycle, pkt_cnt=8.
- Packet atomicity: rr_ptr=1; req1 sends 3 beats (A1,A2,A3, last on A3) while req0 and req2 hold valid single beats -> fifo_din A1,A2,A3 from src 1, then src 2, then src 0; lock_active high for the two cycles after A1.
- Full stall while locked: req2 locked after beat 1; fifo_full=1 for 3 cycles -> fifo_wr_en=0, req_ready=0000, lock_owner=2 held. Full drops -> beat 2 written from src 2 next cycle.
- Owner bubble: req3 locked, req_valid[3]=0 for 2 cycles, req0 valid -> no writes and req_ready[0]=0. req3 resumes with last -> written, then req0 granted.
- Async reset mid-packet: rstn low between clock edges while req1 locked -> lock_active=0 immediately (before the next edge). After release with req1 and req0 valid -> req0 granted first, pkt_cnt=0.
